// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download path: address width, colour-PROM
// windows and the serialiser state encoding.
package ioctl_pkg;

   localparam int IOCTL_ADDR_W = 25;

   localparam logic [IOCTL_ADDR_W-1:0] PROM_R_BASE = 25'h80_000;
   localparam logic [IOCTL_ADDR_W-1:0] PROM_G_BASE = 25'h80_400;
   localparam logic [IOCTL_ADDR_W-1:0] PROM_B_BASE = 25'h80_800;
   localparam logic [IOCTL_ADDR_W-1:0] PROM_SIZE   = 25'h400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/sync_fifo_word.sv
// Small synchronous word FIFO. The head of the queue is kept in a register so
// the consumer sees the oldest word as a flop output the cycle after it lands.
module sync_fifo_word #(
   parameter int WIDTH = 57,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nx;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Read pointer as it will stand after this edge, used to preload the head.
   always_comb begin
      rd_ptr_nx = rd_ptr;
      if (do_pop) rd_ptr_nx = rd_ptr + 1'b1;
   end

   // Storage array; no reset needed since occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nx;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head register; a push landing in the next head slot is forwarded directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_data <= '0;
      end else if (do_push && (wr_ptr == rd_ptr_nx)) begin
         head_data <= push_data;
      end else begin
         head_data <= mem[rd_ptr_nx];
      end
   end

endmodule

// File: rtl/ioctl_bridge_tx.sv
// Transmit side of the byte-wide ioctl download port: buffers 32-bit words and
// replays each one as four spaced byte writes at consecutive addresses.
module ioctl_bridge_tx
   import ioctl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WR_GAP     = 3,
   parameter int ADDR_W     = IOCTL_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dl_active,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_data,
   output logic              ioctl_download,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_data,
   output logic              ioctl_wr,
   output logic              busy
);

   localparam int WORD_W = ADDR_W + 32;

   tx_state_t         state;
   tx_state_t         state_nx;
   logic [WORD_W-1:0] push_word;
   logic [WORD_W-1:0] head_word;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              load_first;
   logic              load_next;
   logic              gap_load;
   logic [ADDR_W-3:0] base_hi;
   logic [23:0]       shift_reg;
   logic [1:0]        byte_idx;
   logic [3:0]        gap_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              dl_q;
   logic              busy_int;
   logic              unused_bits;

   assign push_word   = {in_addr[ADDR_W-1:2], 2'b00, in_data};
   assign unused_bits = ^{in_addr[1:0], head_word[33:32]};
   assign in_ready    = ~fifo_full & ~rst;
   assign push        = in_valid & in_ready;
   assign busy_int    = ~fifo_empty | (state != IDLE);

   assign ioctl_wr       = (state == EMIT) & ~rst;
   assign ioctl_addr     = rst ? '0 : addr_q;
   assign ioctl_data     = rst ? '0 : data_q;
   assign ioctl_download = dl_q & ~rst;
   assign busy           = busy_int & ~rst;

   sync_fifo_word #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .head_data (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Serialiser state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state plus the load/pop strobes that steer the datapath.
   always_comb begin
      state_nx   = state;
      pop        = 1'b0;
      load_first = 1'b0;
      load_next  = 1'b0;
      gap_load   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               load_first = 1'b1;
               state_nx   = EMIT;
            end
         end
         EMIT: begin
            if (WR_GAP > 0) begin
               gap_load = 1'b1;
               state_nx = GAP;
            end else if (byte_idx == 2'd3) begin
               state_nx = IDLE;
            end else begin
               load_next = 1'b1;
               state_nx  = EMIT;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd1) begin
               if (byte_idx == 2'd3) begin
                  state_nx = IDLE;
               end else begin
                  load_next = 1'b1;
                  state_nx  = EMIT;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Byte datapath: outputs only move when a strobe cycle is being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_hi   <= '0;
         shift_reg <= '0;
         byte_idx  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else if (load_first) begin
         base_hi   <= head_word[WORD_W-1:34];
         addr_q    <= {head_word[WORD_W-1:34], 2'b00};
         data_q    <= head_word[31:24];
         shift_reg <= head_word[23:0];
         byte_idx  <= 2'd0;
      end else if (load_next) begin
         addr_q    <= {base_hi, byte_idx + 2'd1};
         data_q    <= shift_reg[23:16];
         shift_reg <= {shift_reg[15:0], 8'h00};
         byte_idx  <= byte_idx + 2'd1;
      end
   end

   // Idle-spacing counter between write strobes.
   always_ff @(posedge clk) begin
      if (rst)                gap_cnt <= '0;
      else if (gap_load)      gap_cnt <= 4'(WR_GAP);
      else if (state == GAP)  gap_cnt <= gap_cnt - 4'd1;
   end

   // Download window stays open until the bridge is done and we have drained.
   always_ff @(posedge clk) begin
      if (rst) dl_q <= 1'b0;
      else     dl_q <= dl_active | (dl_q & busy_int);
   end

endmodule

// File: tb/tb_ioctl_bridge_tx.sv
// Directed bench for ioctl_bridge_tx: one instance with the default spacing
// and one with zero spacing, sharing the stimulus bus via a select line.
module tb_ioctl_bridge_tx;
   import ioctl_pkg::*;

   typedef struct {
      int          cyc;
      logic [24:0] addr;
      logic [7:0]  data;
   } wr_rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dl_active;
   logic        in_valid;
   logic        sel0;
   logic [24:0] in_addr;
   logic [31:0] in_data;

   logic        valid_a, ready_a, dl_a, wr_a, busy_a;
   logic [24:0] addr_a;
   logic [7:0]  data_a;
   logic        valid_b, ready_b, dl_b, wr_b, busy_b;
   logic [24:0] addr_b;
   logic [7:0]  data_b;

   int      cyc = 0;
   int      n_cmp = 0;
   int      n_fail = 0;
   wr_rec_t wr_a_q[$];
   wr_rec_t wr_b_q[$];
   int      acc_a_q[$];
   int      acc_b_q[$];
   wr_rec_t rec_a, rec_b;

   assign valid_a = in_valid & ~sel0;
   assign valid_b = in_valid & sel0;

   ioctl_bridge_tx #(.FIFO_DEPTH(4), .WR_GAP(3), .ADDR_W(25)) dut (
      .clk(clk), .rst(rst), .dl_active(dl_active),
      .in_valid(valid_a), .in_ready(ready_a), .in_addr(in_addr), .in_data(in_data),
      .ioctl_download(dl_a), .ioctl_addr(addr_a), .ioctl_data(data_a),
      .ioctl_wr(wr_a), .busy(busy_a)
   );

   ioctl_bridge_tx #(.FIFO_DEPTH(4), .WR_GAP(0), .ADDR_W(25)) dut0 (
      .clk(clk), .rst(rst), .dl_active(dl_active),
      .in_valid(valid_b), .in_ready(ready_b), .in_addr(in_addr), .in_data(in_data),
      .ioctl_download(dl_b), .ioctl_addr(addr_b), .ioctl_data(data_b),
      .ioctl_wr(wr_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   // Cycle number; a cycle starts at a rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Record accepted words and write strobes away from the active edge.
   always @(negedge clk) begin
      if (valid_a && ready_a) acc_a_q.push_back(cyc);
      if (valid_b && ready_b) acc_b_q.push_back(cyc);
      if (wr_a) begin
         rec_a.cyc = cyc; rec_a.addr = addr_a; rec_a.data = data_a;
         wr_a_q.push_back(rec_a);
      end
      if (wr_b) begin
         rec_b.cyc = cyc; rec_b.addr = addr_b; rec_b.data = data_b;
         wr_b_q.push_back(rec_b);
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clear_logs();
      wr_a_q.delete(); wr_b_q.delete(); acc_a_q.delete(); acc_b_q.delete();
   endtask

   // Present one word and hold it until accepted; called at posedge+1.
   task automatic drive_word(input logic [24:0] a, input logic [31:0] d,
                             output bit ok, output bit stalled);
      int waited = 0;
      ok = 1'b0;
      in_valid = 1'b1; in_addr = a; in_data = d;
      while (waited < 100) begin
         @(negedge clk);
         if (sel0 ? ready_b : ready_a) begin
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
         waited++;
      end
      stalled = (waited > 0);
   endtask

   // Wait for busy to fall; reports the first idle cycle, or -1 on timeout.
   task automatic wait_idle(input bit which, output int at);
      at = -1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!(which ? busy_b : busy_a)) begin
            at = cyc;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; dl_active = 1'b0; sel0 = 1'b0;
      in_addr = '0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++; if (wr_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_wr: got %b want 0", wr_a); end
      n_cmp++; if (addr_a !== 25'h0) begin n_fail++; $display("[TB] FAIL rst_addr: got %h want 0", addr_a); end
      n_cmp++; if (data_a !== 8'h0)  begin n_fail++; $display("[TB] FAIL rst_data: got %h want 0", data_a); end
      n_cmp++; if (dl_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_download: got %b want 0", dl_a); end
      n_cmp++; if (busy_a !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy_a); end
      n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b want 0", ready_a); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_ready: got %b want 1", ready_a); end
      n_cmp++; if (ready_b !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_ready0: got %b want 1", ready_b); end
      n_cmp++; if (busy_a !== 1'b0)  begin n_fail++; $display("[TB] FAIL post_rst_busy: got %b want 0", busy_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_download_window();
      bit ok, st;
      int at, low_mid, n0;
      logic dl_at_idle;
      clear_logs();
      dl_active = 1'b1;
      @(negedge clk);
      n_cmp++; if (dl_a !== 1'b0) begin n_fail++; $display("[TB] FAIL dl_set_early: got %b want 0", dl_a); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (dl_a !== 1'b1) begin n_fail++; $display("[TB] FAIL dl_set: got %b want 1", dl_a); end
      @(posedge clk); #1;
      drive_word(25'h80_020, 32'h0A0B0C0D, ok, st);
      drive_word(25'h80_024, 32'h1A1B1C1D, ok, st);
      in_valid = 1'b0;
      dl_active = 1'b0;
      at = -1; low_mid = 0; dl_at_idle = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (busy_a) begin
            if (!dl_a) low_mid++;
         end else begin
            at = cyc; dl_at_idle = dl_a;
            break;
         end
      end
      @(negedge clk);
      n0 = (acc_a_q.size() > 0) ? acc_a_q[0] : -1000;
      n_cmp++; if (low_mid !== 0) begin n_fail++; $display("[TB] FAIL dl_mid_low: got %0d low cycles want 0", low_mid); end
      n_cmp++; if (at !== n0 + 35) begin n_fail++; $display("[TB] FAIL dl_drain_cycle: got %0d want %0d", at, n0 + 35); end
      n_cmp++; if (dl_at_idle !== 1'b1) begin n_fail++; $display("[TB] FAIL dl_at_idle: got %b want 1", dl_at_idle); end
      n_cmp++; if (dl_a !== 1'b0) begin n_fail++; $display("[TB] FAIL dl_clear: got %b want 0", dl_a); end
      n_cmp++; if (wr_a_q.size() !== 8) begin n_fail++; $display("[TB] FAIL dl_strobes: got %0d want 8", wr_a_q.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      bit ok, st;
      int at, n0;
      logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      clear_logs();
      dl_active = 1'b1;
      drive_word(PROM_R_BASE, 32'h11223344, ok, st);
      in_valid = 1'b0;
      wait_idle(1'b0, at);
      n0 = (acc_a_q.size() > 0) ? acc_a_q[0] : -1000;
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_accept: got %b want 1", ok); end
      n_cmp++; if (wr_a_q.size() !== 4) begin n_fail++; $display("[TB] FAIL single_count: got %0d want 4", wr_a_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < wr_a_q.size()) begin
            n_cmp++; if (wr_a_q[i].cyc !== n0 + 2 + 4*i) begin n_fail++; $display("[TB] FAIL single_cyc%0d: got %0d want %0d", i, wr_a_q[i].cyc, n0 + 2 + 4*i); end
            n_cmp++; if (wr_a_q[i].addr !== PROM_R_BASE + 25'(i)) begin n_fail++; $display("[TB] FAIL single_addr%0d: got %h want %h", i, wr_a_q[i].addr, PROM_R_BASE + 25'(i)); end
            n_cmp++; if (wr_a_q[i].data !== exp_d[i]) begin n_fail++; $display("[TB] FAIL single_data%0d: got %h want %h", i, wr_a_q[i].data, exp_d[i]); end
         end
      end
      n_cmp++; if (at !== n0 + 18) begin n_fail++; $display("[TB] FAIL single_idle: got %0d want %0d", at, n0 + 18); end
   endtask

   task automatic test_back_pressure();
      bit ok, st;
      int at, n0, first_stall, exp_cyc;
      clear_logs();
      first_stall = -1;
      for (int k = 0; k < 8; k++) begin
         drive_word(PROM_G_BASE + 25'(4*k),
                    {8'(64 + 4*k), 8'(65 + 4*k), 8'(66 + 4*k), 8'(67 + 4*k)}, ok, st);
         if (st && first_stall < 0) first_stall = k;
      end
      in_valid = 1'b0;
      wait_idle(1'b0, at);
      n0 = (acc_a_q.size() > 0) ? acc_a_q[0] : -1000;
      n_cmp++; if (!(first_stall == 4 || first_stall == 5)) begin n_fail++; $display("[TB] FAIL bp_first_stall: got %0d want 4 or 5", first_stall); end
      n_cmp++; if (acc_a_q.size() !== 8) begin n_fail++; $display("[TB] FAIL bp_accepts: got %0d want 8", acc_a_q.size()); end
      n_cmp++; if (wr_a_q.size() !== 32) begin n_fail++; $display("[TB] FAIL bp_count: got %0d want 32", wr_a_q.size()); end
      for (int n = 0; n < 32; n++) begin
         if (n < wr_a_q.size()) begin
            exp_cyc = n0 + 2 + 4*n + n/4;
            n_cmp++; if (wr_a_q[n].cyc !== exp_cyc) begin n_fail++; $display("[TB] FAIL bp_cyc%0d: got %0d want %0d", n, wr_a_q[n].cyc, exp_cyc); end
            n_cmp++; if (wr_a_q[n].addr !== PROM_G_BASE + 25'(n)) begin n_fail++; $display("[TB] FAIL bp_addr%0d: got %h want %h", n, wr_a_q[n].addr, PROM_G_BASE + 25'(n)); end
            n_cmp++; if (wr_a_q[n].data !== 8'(64 + n)) begin n_fail++; $display("[TB] FAIL bp_data%0d: got %h want %h", n, wr_a_q[n].data, 8'(64 + n)); end
         end
      end
      n_cmp++; if (at !== n0 + 137) begin n_fail++; $display("[TB] FAIL bp_idle: got %0d want %0d", at, n0 + 137); end
   endtask

   task automatic test_misaligned_wrap();
      bit ok, st;
      int at;
      logic [7:0] exp_d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      clear_logs();
      drive_word(25'h1FF_FFFE, 32'hA1B2C3D4, ok, st);
      in_valid = 1'b0;
      wait_idle(1'b0, at);
      n_cmp++; if (wr_a_q.size() !== 4) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d want 4", wr_a_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < wr_a_q.size()) begin
            n_cmp++; if (wr_a_q[i].addr !== 25'h1FF_FFFC + 25'(i)) begin n_fail++; $display("[TB] FAIL wrap_addr%0d: got %h want %h", i, wr_a_q[i].addr, 25'h1FF_FFFC + 25'(i)); end
            n_cmp++; if (wr_a_q[i].data !== exp_d[i]) begin n_fail++; $display("[TB] FAIL wrap_data%0d: got %h want %h", i, wr_a_q[i].data, exp_d[i]); end
         end
      end
   endtask

   task automatic test_gap0();
      bit ok, st;
      int at, n0, exp_cyc;
      clear_logs();
      sel0 = 1'b1;
      drive_word(25'h000_100, 32'h01020304, ok, st);
      drive_word(25'h000_104, 32'h05060708, ok, st);
      in_valid = 1'b0;
      wait_idle(1'b1, at);
      sel0 = 1'b0;
      n0 = (acc_b_q.size() > 0) ? acc_b_q[0] : -1000;
      n_cmp++; if (wr_b_q.size() !== 8) begin n_fail++; $display("[TB] FAIL gap0_count: got %0d want 8", wr_b_q.size()); end
      for (int n = 0; n < 8; n++) begin
         if (n < wr_b_q.size()) begin
            exp_cyc = n0 + 2 + n + ((n >= 4) ? 1 : 0);
            n_cmp++; if (wr_b_q[n].cyc !== exp_cyc) begin n_fail++; $display("[TB] FAIL gap0_cyc%0d: got %0d want %0d", n, wr_b_q[n].cyc, exp_cyc); end
            n_cmp++; if (wr_b_q[n].addr !== 25'h100 + 25'(n)) begin n_fail++; $display("[TB] FAIL gap0_addr%0d: got %h want %h", n, wr_b_q[n].addr, 25'h100 + 25'(n)); end
            n_cmp++; if (wr_b_q[n].data !== 8'(n + 1)) begin n_fail++; $display("[TB] FAIL gap0_data%0d: got %h want %h", n, wr_b_q[n].data, 8'(n + 1)); end
         end
      end
   endtask

   task automatic test_reset_mid_word();
      bit ok, st;
      int at, n0;
      logic [7:0] exp_d [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
      clear_logs();
      dl_active = 1'b1;
      drive_word(PROM_B_BASE, 32'hDEADBEEF, ok, st);
      in_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (wr_a_q.size() >= 2) break;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (wr_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL midrst_wr: got %b want 0", wr_a); end
      n_cmp++; if (addr_a !== 25'h0) begin n_fail++; $display("[TB] FAIL midrst_addr: got %h want 0", addr_a); end
      n_cmp++; if (data_a !== 8'h0)  begin n_fail++; $display("[TB] FAIL midrst_data: got %h want 0", data_a); end
      n_cmp++; if (dl_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL midrst_download: got %b want 0", dl_a); end
      n_cmp++; if (busy_a !== 1'b0)  begin n_fail++; $display("[TB] FAIL midrst_busy: got %b want 0", busy_a); end
      n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b want 0", ready_a); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++; if (wr_a_q.size() !== 2) begin n_fail++; $display("[TB] FAIL midrst_strobes: got %0d want 2", wr_a_q.size()); end
      if (wr_a_q.size() >= 2) begin
         n_cmp++; if (wr_a_q[1].data !== 8'hAD) begin n_fail++; $display("[TB] FAIL midrst_second: got %h want ad", wr_a_q[1].data); end
      end
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_idle: got %b want 0", busy_a); end
      @(posedge clk); #1;
      clear_logs();
      drive_word(25'h80_810, 32'h55667788, ok, st);
      in_valid = 1'b0;
      wait_idle(1'b0, at);
      n0 = (acc_a_q.size() > 0) ? acc_a_q[0] : -1000;
      n_cmp++; if (wr_a_q.size() !== 4) begin n_fail++; $display("[TB] FAIL rerun_count: got %0d want 4", wr_a_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < wr_a_q.size()) begin
            n_cmp++; if (wr_a_q[i].cyc !== n0 + 2 + 4*i) begin n_fail++; $display("[TB] FAIL rerun_cyc%0d: got %0d want %0d", i, wr_a_q[i].cyc, n0 + 2 + 4*i); end
            n_cmp++; if (wr_a_q[i].addr !== 25'h80_810 + 25'(i)) begin n_fail++; $display("[TB] FAIL rerun_addr%0d: got %h want %h", i, wr_a_q[i].addr, 25'h80_810 + 25'(i)); end
            n_cmp++; if (wr_a_q[i].data !== exp_d[i]) begin n_fail++; $display("[TB] FAIL rerun_data%0d: got %h want %h", i, wr_a_q[i].data, exp_d[i]); end
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      rst = 1'b1; in_valid = 1'b0; dl_active = 1'b0; sel0 = 1'b0;
      in_addr = '0; in_data = '0;
      $display("[TB] start");
      test_reset();
      test_download_window();
      test_single_word();
      test_back_pressure();
      test_misaligned_wrap();
      test_gap0();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
